// File: rtl/cache_pkg.sv
// Shared definitions for the 4-way data cache controller and its datapath:
// state encoding, strobe bit positions and way/LRU widths.
package cache_pkg;

  localparam int unsigned WAYS        = 4;
  localparam int unsigned LRU_W       = $clog2(WAYS);
  localparam int unsigned STATE_W     = 4;
  localparam int unsigned NUM_STROBES = 8;

  localparam int unsigned C_LATCH    = 0;
  localparam int unsigned C_RD       = 1;
  localparam int unsigned C_WR       = 2;
  localparam int unsigned C_ACCESS   = 3;
  localparam int unsigned C_ASK      = 4;
  localparam int unsigned C_FREE_SEL = 5;
  localparam int unsigned C_LOAD     = 6;
  localparam int unsigned C_LRU_SEL  = 7;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE        = 4'd0,
    ST_LATCH       = 4'd1,
    ST_LOOKUP      = 4'd2,
    ST_ACCESS      = 4'd3,
    ST_SELECT      = 4'd4,
    ST_VICTIM      = 4'd5,
    ST_WB          = 4'd6,
    ST_REFILL_REQ  = 4'd7,
    ST_REFILL_WAIT = 4'd8,
    ST_LOAD        = 4'd9,
    ST_DONE        = 4'd10
  } state_e;

  // Strobe pattern the cache datapath sees while the controller sits in state s.
  function automatic logic [NUM_STROBES-1:0] strobes_for(input state_e s, input logic we);
    logic [NUM_STROBES-1:0] v;
    v = '0;
    case (s)
      ST_LATCH:      v[C_LATCH] = 1'b1;
      ST_ACCESS: begin
        v[C_RD]     = ~we;
        v[C_WR]     = we;
        v[C_ACCESS] = 1'b1;
      end
      ST_SELECT:     v[C_FREE_SEL] = 1'b1;
      ST_VICTIM:     v[C_LRU_SEL]  = 1'b1;
      ST_REFILL_REQ: v[C_ASK]      = 1'b1;
      ST_LOAD:       v[C_LOAD]     = 1'b1;
      default:       v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cache_controller_timer.sv
// Cycle counter with load/enable; expire is high on the last enabled cycle
// before the count would reach limit.
module mem_timeout_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= '0;
    else if (en)   cnt <= cnt + W'(1);
  end

  assign expire = en && (cnt == limit - W'(1));

endmodule

// File: rtl/cache_controller.sv
// Sequencing FSM for the 4-way set-associative data cache: CPU handshake,
// lookup/access strobes, victim write-back, refill and replay.
//
// state       | meaning
// IDLE        | waiting for cpu_req
// LATCH       | c0: cache latches address/data
// LOOKUP      | tag compare settling (LOOKUP_CYCLES)
// ACCESS      | c1/c2 + c3: hit access, sample hit/miss
// SELECT      | c5: look for a free way
// VICTIM      | c7: LRU victim chosen, check its dirty bit
// WB          | write back dirty victim to memory
// REFILL_REQ  | c4: ask cache to prepare refill
// REFILL_WAIT | read block from memory
// LOAD        | c6: load refill data, then replay
// DONE        | cpu_ack (and cpu_err on failure)
module cache_controller
  import cache_pkg::*;
#(
  parameter int LOOKUP_CYCLES = 2,
  parameter int MEM_TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_req,
  input  logic            cpu_we,
  output logic            cpu_ack,
  output logic            cpu_err,
  input  logic            hit,
  input  logic            miss,
  input  logic            free,
  input  logic [WAYS-1:0] dirty,
  input  logic [WAYS-1:0] and_val,
  output logic            c0,
  output logic            c1,
  output logic            c2,
  output logic            c3,
  output logic            c4,
  output logic            c5,
  output logic            c6,
  output logic            c7,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ready,
  output logic            busy
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_e                 state, state_d;
  logic                   we_q, we_d;
  logic                   retry_q, retry_d;
  logic                   err_d;
  logic                   tmr_load, tmr_en, tmr_expire;
  logic [TW-1:0]          tmr_limit;
  logic [NUM_STROBES-1:0] strobe_q, strobe_d;
  logic                   ack_d, mem_req_d, mem_we_d, busy_d;

  // One timer serves both the lookup delay and the memory wait; every state
  // that uses it is entered from exactly one predecessor, which does the load.
  assign tmr_load  = state inside {ST_LATCH, ST_VICTIM, ST_REFILL_REQ};
  assign tmr_en    = state inside {ST_LOOKUP, ST_WB, ST_REFILL_WAIT};
  assign tmr_limit = (state == ST_LOOKUP) ? TW'(LOOKUP_CYCLES) : TW'(MEM_TIMEOUT);

  mem_timeout_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .en     (tmr_en),
    .limit  (tmr_limit),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d = state;
    we_d    = we_q;
    retry_d = retry_q;
    err_d   = 1'b0;
    case (state)
      ST_IDLE: if (cpu_req) begin
        state_d = ST_LATCH;
        we_d    = cpu_we;
      end
      ST_LATCH:  state_d = ST_LOOKUP;
      ST_LOOKUP: if (tmr_expire) state_d = ST_ACCESS;
      ST_ACCESS: begin
        // Inconsistent hit/miss is a datapath fault and takes the miss path.
        if (hit && !miss) begin
          state_d = ST_DONE;
        end else if (retry_q) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: state_d = free ? ST_REFILL_REQ : ST_VICTIM;
      ST_VICTIM: state_d = |(dirty & and_val) ? ST_WB : ST_REFILL_REQ;
      ST_WB: begin
        if (mem_ready) begin
          state_d = ST_REFILL_REQ;
        end else if (tmr_expire) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_REFILL_REQ: state_d = ST_REFILL_WAIT;
      ST_REFILL_WAIT: begin
        if (mem_ready) begin
          state_d = ST_LOAD;
        end else if (tmr_expire) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_LOAD: begin
        retry_d = 1'b1;
        state_d = ST_LATCH;
      end
      ST_DONE: begin
        retry_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    strobe_d  = strobes_for(state_d, we_d);
    ack_d     = (state_d == ST_DONE);
    mem_req_d = state_d inside {ST_WB, ST_REFILL_WAIT};
    mem_we_d  = (state_d == ST_WB);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      we_q     <= 1'b0;
      retry_q  <= 1'b0;
      strobe_q <= '0;
      cpu_ack  <= 1'b0;
      cpu_err  <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      we_q     <= we_d;
      retry_q  <= retry_d;
      strobe_q <= strobe_d;
      cpu_ack  <= ack_d;
      cpu_err  <= err_d;
      mem_req  <= mem_req_d;
      mem_we   <= mem_we_d;
      busy     <= busy_d;
    end
  end

  assign c0 = strobe_q[C_LATCH];
  assign c1 = strobe_q[C_RD];
  assign c2 = strobe_q[C_WR];
  assign c3 = strobe_q[C_ACCESS];
  assign c4 = strobe_q[C_ASK];
  assign c5 = strobe_q[C_FREE_SEL];
  assign c6 = strobe_q[C_LOAD];
  assign c7 = strobe_q[C_LRU_SEL];

endmodule
